// File: rtl/lrf_pkg.sv
// Shared constants for the frame loader: geometry defaults, FSM encoding, status bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lrf_pkg;

  localparam int LRF_IMAGE_DIM       = 512;
  localparam int LRF_PIXEL_WIDTH     = 8;
  localparam int LRF_PIXELS_PER_BEAT = 16;
  localparam int LRF_DATA_WIDTH      = LRF_PIXEL_WIDTH * LRF_PIXELS_PER_BEAT;
  localparam int LRF_ADDR_WIDTH      = 14;

  // Loader FSM encoding; kept as plain constants so older tools and dumps read the same codes.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_LOAD     = 2'd2;

  // Number of beats a full frame occupies in the store.
  function automatic int frame_beats(input int dim, input int ppb);
    return (dim * dim) / ppb;
  endfunction

  localparam int LRF_BEATS_PER_FRAME = frame_beats(LRF_IMAGE_DIM, LRF_PIXELS_PER_BEAT);

  // End-of-frame status, registered and presented as one-cycle pulses.
  typedef struct packed {
    logic done;
    logic error;
  } frame_status_t;

endpackage

// File: rtl/lsu_frame_loader_pixel_packer.sv
// Pixel packer: gathers pixels into lanes of a beat and emits the beat with its index.
// Latency: beat appears one cycle after the push that fills lane 15 or carries flush.
// Backpressure: none; every push is absorbed, a full beat is emitted without stalling.
module pixel_packer
  import lrf_pkg::*;
#(
  parameter int PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
  parameter int PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
  parameter int ADDR_WIDTH      = LRF_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  logic [PIXEL_WIDTH-1:0]                 pixel,
  input  logic                                   clear,
  input  logic                                   flush,
  output logic                                   beat_valid,
  output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] beat_data,
  output logic [ADDR_WIDTH-1:0]                  beat_index
);

  localparam int LANE_W = $clog2(PIXELS_PER_BEAT);
  localparam int DW     = PIXEL_WIDTH * PIXELS_PER_BEAT;

  logic [LANE_W-1:0]     lane_cnt;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [DW-1:0]         lane_reg;

  logic [LANE_W-1:0]     lane_base;
  logic [ADDR_WIDTH-1:0] beat_base;
  logic [DW-1:0]         lane_merged;
  logic                  beat_close;

  // Clear acts before the push so a restart pixel lands in lane 0 of beat 0.
  always_comb begin
    lane_base   = clear ? '0 : lane_cnt;
    beat_base   = clear ? '0 : beat_cnt;
    lane_merged = clear ? '0 : lane_reg;
    lane_merged[lane_base*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel;
    beat_close  = push && (flush || (lane_base == LANE_W'(PIXELS_PER_BEAT - 1)));
  end

  // Lane state and emitted beat; lanes are zeroed after each beat so a flushed beat pads with 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      beat_cnt   <= '0;
      lane_reg   <= '0;
      beat_valid <= 1'b0;
      beat_data  <= '0;
      beat_index <= '0;
    end else begin
      beat_valid <= beat_close;
      if (beat_close) begin
        beat_data  <= lane_merged;
        beat_index <= beat_base;
      end
      if (push) begin
        if (beat_close) begin
          lane_reg <= '0;
          lane_cnt <= '0;
          beat_cnt <= beat_base + 1'b1;
        end else begin
          lane_reg <= lane_merged;
          lane_cnt <= lane_base + 1'b1;
          beat_cnt <= beat_base;
        end
      end else if (clear) begin
        lane_reg <= '0;
        lane_cnt <= '0;
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lsu_frame_loader.sv
// Frame loader: packs a raster pixel stream into beats for the frame store and checks frame length.
// Latency: write strobe one cycle after the accepting edge of a beat's last pixel; status pulses with it.
// Backpressure: never stalls the store; s_ready is low outside an armed frame (excess pixels held off).
module lsu_frame_loader
  import lrf_pkg::*;
#(
  parameter int IMAGE_DIM       = LRF_IMAGE_DIM,
  parameter int PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
  parameter int PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
  parameter int DATA_WIDTH      = LRF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = LRF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                   s_sof,
  input  logic                   s_eof,
  output logic                   write_enable,
  output logic [ADDR_WIDTH-1:0]  write_ptr,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_error
);

  localparam int NUM_PIXELS = IMAGE_DIM * IMAGE_DIM;
  localparam int CNT_W      = $clog2(NUM_PIXELS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] pixel_cnt, cnt_nxt;
  frame_status_t    status_q, status_nxt;

  logic             accept;
  logic [CNT_W-1:0] pixel_idx;
  logic             last_pix;
  logic             push;
  logic             clear;
  logic             flush;

  assign busy        = (state == ST_WAIT_SOF) || (state == ST_LOAD);
  assign s_ready     = busy;
  assign accept      = s_valid && s_ready;
  assign frame_done  = status_q.done;
  assign frame_error = status_q.error;

  // Index of the pixel on the bus: a SOF pixel always restarts numbering at 0.
  always_comb begin
    pixel_idx = s_sof ? '0 : pixel_cnt;
    last_pix  = (pixel_idx == LAST_IDX);
    push      = accept && ((state == ST_LOAD) || s_sof);
    clear     = accept && s_sof;
    flush     = push && (s_eof || last_pix);
  end

  // Frame sequencing: arm, SOF hunt, length checks at EOF or at the last legal pixel.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = pixel_cnt;
    status_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (arm) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (accept && s_sof) begin
          if (s_eof) begin
            state_nxt        = ST_IDLE;
            cnt_nxt          = '0;
            status_nxt.error = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (s_sof) status_nxt.error = 1'b1;
          if (s_eof) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            if (last_pix) status_nxt.done  = 1'b1;
            else          status_nxt.error = 1'b1;
          end else if (last_pix) begin
            state_nxt        = ST_IDLE;
            cnt_nxt          = '0;
            status_nxt.error = 1'b1;
          end else begin
            cnt_nxt = pixel_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, pixel counter and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pixel_cnt <= '0;
      status_q  <= '0;
    end else begin
      state     <= state_nxt;
      pixel_cnt <= cnt_nxt;
      status_q  <= status_nxt;
    end
  end

  pixel_packer #(
    .PIXEL_WIDTH     (PIXEL_WIDTH),
    .PIXELS_PER_BEAT (PIXELS_PER_BEAT),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pixel      (s_data),
    .clear      (clear),
    .flush      (flush),
    .beat_valid (write_enable),
    .beat_data  (write_data),
    .beat_index (write_ptr)
  );

endmodule

// File: tb/tb_lsu_frame_loader.sv
// Bench for lsu_frame_loader on a reduced 64x64 frame (4096 pixels, 256 beats).
// Expected beats come from the list of pixels that make up the frame, chunked by 16.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_lsu_frame_loader;

  localparam int DIM = 64;
  localparam int N   = DIM * DIM;
  localparam int NB  = N / 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arm = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = '0;
  logic         s_sof = 1'b0;
  logic         s_eof = 1'b0;
  logic         write_enable;
  logic [13:0]  write_ptr;
  logic [127:0] write_data;
  logic         busy;
  logic         frame_done;
  logic         frame_error;

  lsu_frame_loader #(.IMAGE_DIM(DIM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_eof        (s_eof),
    .write_enable (write_enable),
    .write_ptr    (write_ptr),
    .write_data   (write_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0]  cap_ptr[$];
  logic [127:0] cap_data[$];
  logic [1:0]   cap_flag[$];
  int           done_cnt = 0;
  int           err_cnt  = 0;
  logic [7:0]   exp_pix[$];

  // Write-port monitor
  always @(negedge clk) begin
    if (write_enable) begin
      cap_ptr.push_back(write_ptr);
      cap_data.push_back(write_data);
      cap_flag.push_back({frame_done, frame_error});
    end
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_capture();
    cap_ptr.delete();
    cap_data.delete();
    cap_flag.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Expected beat b of the frame held in exp_pix, unused lanes zero.
  function automatic logic [127:0] model_beat(input int b);
    logic [127:0] d;
    d = '0;
    for (int l = 0; l < 16; l++)
      if (b * 16 + l < exp_pix.size()) d[l*8 +: 8] = exp_pix[b*16 + l];
    return d;
  endfunction

  task automatic send_pixel(input logic [7:0] d, input bit sof, input bit eof);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("ready_timeout", 128'(s_ready), 128'(1));
    @(negedge clk);
  endtask

  task automatic idle_bus();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic run_frame(input int junk, input int len, input bit with_eof,
                           input bit gaps, input bit rnd, input logic [7:0] xr);
    logic [7:0] d;
    exp_pix.delete();
    clear_capture();
    pulse_arm();
    for (int j = 0; j < junk; j++) send_pixel(8'(8'hFF - j), 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        idle_bus();
        @(negedge clk);
      end
      d = rnd ? 8'($urandom) : (8'(i) ^ xr);
      send_pixel(d, i == 0, with_eof && (i == len - 1));
      exp_pix.push_back(d);
    end
    idle_bus();
    repeat (3) @(negedge clk);
  endtask

  task automatic verify_frame(input string tag, input int base, input int exp_writes,
                              input int exp_last_ptr, input int exp_done, input int exp_err,
                              input logic [1:0] exp_end_flags);
    int nb;
    nb = (exp_pix.size() + 15) / 16;
    chk_i({tag, "_write_count"}, cap_ptr.size(), exp_writes);
    for (int b = 0; b < nb; b++) begin
      if (base + b < cap_ptr.size()) begin
        chk($sformatf("%s_ptr%0d", tag, b), 128'(cap_ptr[base+b]), 128'(b));
        chk($sformatf("%s_data%0d", tag, b), cap_data[base+b], model_beat(b));
      end
    end
    if (cap_ptr.size() > 0) begin
      chk({tag, "_last_ptr"}, 128'(cap_ptr[$]), 128'(exp_last_ptr));
      chk({tag, "_end_flags"}, 128'(cap_flag[$]), 128'(exp_end_flags));
    end
    chk_i({tag, "_done_pulses"}, done_cnt, exp_done);
    chk_i({tag, "_error_pulses"}, err_cnt, exp_err);
    chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    chk({tag, "_ready_after"}, 128'(s_ready), 128'(0));
  endtask

  typedef struct {
    int         junk;
    int         len;
    bit         eof;
    logic [7:0] xr;
    int         writes;
    int         last_ptr;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [127:0] k;
    int           len;

    vecs[0] = '{0, N,  1'b1, 8'h00, NB, NB - 1, 1, 0};
    vecs[1] = '{0, 20, 1'b1, 8'h00, 2,  1,      0, 1};
    vecs[2] = '{5, 1,  1'b1, 8'h5A, 1,  0,      0, 1};
    vecs[3] = '{0, 16, 1'b1, 8'h11, 1,  0,      0, 1};
    vecs[4] = '{2, 17, 1'b1, 8'h22, 2,  1,      0, 1};
    vecs[5] = '{0, N,  1'b0, 8'h33, NB, NB - 1, 0, 1};
    vecs[6] = '{0, 48, 1'b1, 8'h44, 3,  2,      0, 1};

    // Reset state
    #1;
    chk("reset_write_enable", 128'(write_enable), 128'(0));
    chk("reset_write_ptr", 128'(write_ptr), 128'(0));
    chk("reset_write_data", write_data, 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_ready", 128'(s_ready), 128'(0));
    chk("reset_status", 128'({frame_done, frame_error}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 128'(s_ready), 128'(0));

    // Table of whole-frame cases
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].junk, vecs[v].len, vecs[v].eof, 1'b0, 1'b0, vecs[v].xr);
      if (!vecs[v].eof) begin
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (3) @(negedge clk);
        chk("overflow_stall", 128'(s_ready), 128'(0));
        idle_bus();
        @(negedge clk);
      end
      verify_frame($sformatf("vec%0d", v), 0, vecs[v].writes, vecs[v].last_ptr,
                   vecs[v].done, vecs[v].err, {vecs[v].done[0], vecs[v].err[0]});
      if (v == 0 && cap_data.size() > 0) begin
        k = 128'h0F0E0D0C0B0A09080706050403020100;
        chk("full_beat0_const", cap_data[0], k);
      end
      if (v == 1 && cap_data.size() > 1) begin
        k = {96'h0, 32'h13121110};
        chk("short_beat1_const", cap_data[1], k);
      end
    end

    // Full frame with random valid gaps
    run_frame(0, N, 1'b1, 1'b1, 1'b0, 8'h00);
    verify_frame("gapped", 0, NB, NB - 1, 1, 0, 2'b10);

    // Random short frames, random data and gaps
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 200);
      run_frame($urandom_range(0, 4), len, 1'b1, 1'b1, 1'b1, 8'h00);
      verify_frame($sformatf("rnd%0d", r), 0, (len + 15) / 16, (len - 1) / 16, 0, 1, 2'b01);
    end

    // Restart: SOF again on pixel 40, then a complete frame
    clear_capture();
    exp_pix.delete();
    pulse_arm();
    for (int i = 0; i < 40; i++) send_pixel(8'(i), i == 0, 1'b0);
    for (int i = 0; i < N; i++) begin
      send_pixel(8'(i) ^ 8'h3C, i == 0, i == N - 1);
      exp_pix.push_back(8'(i) ^ 8'h3C);
    end
    idle_bus();
    repeat (3) @(negedge clk);
    verify_frame("restart", 2, NB + 2, NB - 1, 1, 1, 2'b10);
    if (cap_flag.size() > 2) chk("restart_first_new_flags", 128'(cap_flag[2]), 128'(0));

    // Reset during pixel 8 of beat 3
    clear_capture();
    pulse_arm();
    for (int i = 0; i < 56; i++) send_pixel(8'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_write_enable", 128'(write_enable), 128'(0));
    chk("midrst_write_ptr", 128'(write_ptr), 128'(0));
    chk("midrst_write_data", write_data, 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ready", 128'(s_ready), 128'(0));
    chk("midrst_status", 128'({frame_done, frame_error}), 128'(0));
    idle_bus();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_i("midrst_writes", cap_ptr.size(), 3);

    // Recovery frame after reset
    run_frame(1, 37, 1'b1, 1'b1, 1'b1, 8'h00);
    verify_frame("recover", 0, 3, 2, 0, 1, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
